boot_screen_ctrl: RTL and testbench

BOOT_SCREEN_CTRL -- requirements
Module: boot_screen_ctrl

---
 rtl/boot_screen_ctrl.sv | 117 +++++++++++
 tb/tb_boot_screen_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_screen_ctrl.sv
// rtl/boot_screen_ctrl.sv - boot logo sequencer: loading animation, logo hold, CPU release
// Single registered Moore FSM; every output comes straight from a flop.
module boot_screen_ctrl #(
   parameter int FRAMES_PER_STEP = 4,
   parameter int OFFSET_STEPS    = 8,
   parameter int HOLD_FRAMES     = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_start,
   input  logic       load_busy,
   input  logic       skip_req,
   output logic [9:0] loading_offset,
   output logic       logo_enable,
   output logic       cpu_reset,
   output logic       boot_done
);

   localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam int OW = (OFFSET_STEPS > 1) ? $clog2(OFFSET_STEPS) : 1;
   localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

   localparam logic [FW-1:0] F_LAST = FW'(FRAMES_PER_STEP - 1);
   localparam logic [OW-1:0] O_LAST = OW'(OFFSET_STEPS - 1);
   localparam logic [HW-1:0] H_LAST = HW'(HOLD_FRAMES - 1);

   typedef enum logic [1:0] {
      S_WAIT = 2'd0,
      S_LOAD = 2'd1,
      S_HOLD = 2'd2,
      S_RUN  = 2'd3
   } state_t;

   state_t        state;
   logic [FW-1:0] frame_cnt;
   logic [HW-1:0] hold_cnt;
   logic [OW-1:0] offset;

   // Zero-extension keeps the bits above the offset modulus at 0.
   assign loading_offset = 10'(offset);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_WAIT;
         frame_cnt   <= '0;
         hold_cnt    <= '0;
         offset      <= '0;
         logo_enable <= 1'b1;
         cpu_reset   <= 1'b1;
         boot_done   <= 1'b0;
      end else begin
         boot_done <= 1'b0;
         case (state)
            S_WAIT: begin
               logo_enable <= 1'b1;
               cpu_reset   <= 1'b1;
               offset      <= '0;
               if (load_busy) begin
                  state     <= S_LOAD;
                  frame_cnt <= '0;
               end else if (skip_req) begin
                  state       <= S_RUN;
                  logo_enable <= 1'b0;
                  cpu_reset   <= 1'b0;
                  boot_done   <= 1'b1;
               end
            end
            S_LOAD: begin
               // Loader finishing beats a coincident frame: that frame is not counted.
               if (!load_busy) begin
                  state    <= S_HOLD;
                  hold_cnt <= '0;
               end else if (frame_start) begin
                  if (frame_cnt == F_LAST) begin
                     frame_cnt <= '0;
                     offset    <= (offset == O_LAST) ? '0 : offset + OW'(1);
                  end else begin
                     frame_cnt <= frame_cnt + FW'(1);
                  end
               end
            end
            S_HOLD: begin
               if (load_busy) begin
                  state     <= S_LOAD;
                  frame_cnt <= '0;
               end else if (skip_req || (frame_start && hold_cnt == H_LAST)) begin
                  state       <= S_RUN;
                  logo_enable <= 1'b0;
                  cpu_reset   <= 1'b0;
                  offset      <= '0;
                  boot_done   <= 1'b1;
               end else if (frame_start) begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            S_RUN: begin
               if (load_busy) begin
                  state       <= S_LOAD;
                  logo_enable <= 1'b1;
                  cpu_reset   <= 1'b1;
                  offset      <= '0;
                  frame_cnt   <= '0;
               end
            end
            default: begin
               state       <= S_WAIT;
               frame_cnt   <= '0;
               hold_cnt    <= '0;
               offset      <= '0;
               logo_enable <= 1'b1;
               cpu_reset   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_boot_screen_ctrl.sv
// tb/tb_boot_screen_ctrl.sv - directed scenario bench for boot_screen_ctrl
module tb_boot_screen_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_start = 1'b0;
   logic       load_busy = 1'b0;
   logic       skip_req = 1'b0;
   logic [9:0] loading_offset;
   logic       logo_enable;
   logic       cpu_reset;
   logic       boot_done;

   int errors = 0;
   int checks = 0;

   boot_screen_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .frame_start    (frame_start),
      .load_busy      (load_busy),
      .skip_req       (skip_req),
      .loading_offset (loading_offset),
      .logo_enable    (logo_enable),
      .cpu_reset      (cpu_reset),
      .boot_done      (boot_done)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      frame_start = 1'b0;
      load_busy = 1'b0;
      skip_req = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Drives a full hold from hold count 0 and checks the release pulse.
   task automatic finish_hold(input string tag, input int exp_off);
      for (int i = 1; i < 30; i++) frame();
      checks++;
      if (cpu_reset !== 1'b1 || boot_done !== 1'b0 || loading_offset !== 10'(exp_off)) begin
         errors++;
         $display("FAIL %s_hold29: got cpu_reset=%0b boot_done=%0b offset=%0d expected 1 0 %0d",
                  tag, cpu_reset, boot_done, loading_offset, exp_off);
      end
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      checks++;
      if (logo_enable !== 1'b0 || cpu_reset !== 1'b0 || loading_offset !== 10'd0 || boot_done !== 1'b1) begin
         errors++;
         $display("FAIL %s_release: got logo=%0b cpu_reset=%0b offset=%0d boot_done=%0b expected 0 0 0 1",
                  tag, logo_enable, cpu_reset, loading_offset, boot_done);
      end
      tick();
      checks++;
      if (boot_done !== 1'b0) begin
         errors++;
         $display("FAIL %s_done_once: got boot_done=%0b expected 0", tag, boot_done);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      frame_start = 1'b1;
      load_busy = 1'b1;
      skip_req = 1'b1;
      tick();
      tick();
      tick();
      checks++;
      if (loading_offset !== 10'd0 || logo_enable !== 1'b1 || cpu_reset !== 1'b1 || boot_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: got offset=%0d logo=%0b cpu_reset=%0b boot_done=%0b expected 0 1 1 0",
                  loading_offset, logo_enable, cpu_reset, boot_done);
      end
      frame_start = 1'b0;
      load_busy = 1'b0;
      skip_req = 1'b0;
      reset = 1'b0;
      tick();
      tick();
      checks++;
      if (cpu_reset !== 1'b1 || boot_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_wait_idle: got cpu_reset=%0b boot_done=%0b expected 1 0", cpu_reset, boot_done);
      end
   endtask

   task automatic test_animation();
      int bad_cpu;
      do_reset();
      load_busy = 1'b1;
      tick();
      bad_cpu = 0;
      for (int i = 1; i <= 20; i++) begin
         frame();
         if (cpu_reset !== 1'b1 || logo_enable !== 1'b1) bad_cpu++;
         if (i % 4 == 0) begin
            checks++;
            if (loading_offset !== 10'(i / 4)) begin
               errors++;
               $display("FAIL anim_frame%0d: got offset=%0d expected %0d", i, loading_offset, i / 4);
            end
         end
      end
      checks++;
      if (bad_cpu != 0) begin
         errors++;
         $display("FAIL anim_cpu_held: got %0d frames with cpu released expected 0", bad_cpu);
      end
   endtask

   task automatic test_wrap();
      int over;
      do_reset();
      load_busy = 1'b1;
      tick();
      over = 0;
      for (int i = 1; i <= 36; i++) begin
         frame();
         if (loading_offset > 10'd7) over++;
         if (i == 28 || i == 32 || i == 36) begin
            checks++;
            if (loading_offset !== ((i == 28) ? 10'd7 : (i == 32) ? 10'd0 : 10'd1)) begin
               errors++;
               $display("FAIL wrap_frame%0d: got offset=%0d expected %0d", i, loading_offset,
                        (i == 28) ? 7 : (i == 32) ? 0 : 1);
            end
         end
      end
      checks++;
      if (over != 0) begin
         errors++;
         $display("FAIL wrap_range: got %0d samples above 7 expected 0", over);
      end
   endtask

   task automatic test_full_boot();
      do_reset();
      load_busy = 1'b1;
      tick();
      for (int i = 1; i <= 10; i++) frame();
      checks++;
      if (loading_offset !== 10'd2) begin
         errors++;
         $display("FAIL boot_load_offset: got %0d expected 2", loading_offset);
      end
      load_busy = 1'b0;
      tick();
      finish_hold("boot", 2);
   endtask

   task automatic test_skip();
      do_reset();
      skip_req = 1'b1;
      tick();
      skip_req = 1'b0;
      checks++;
      if (boot_done !== 1'b1 || cpu_reset !== 1'b0 || logo_enable !== 1'b0) begin
         errors++;
         $display("FAIL skip_wait: got boot_done=%0b cpu_reset=%0b logo=%0b expected 1 0 0",
                  boot_done, cpu_reset, logo_enable);
      end
      do_reset();
      load_busy = 1'b1;
      tick();
      skip_req = 1'b1;
      tick();
      skip_req = 1'b0;
      checks++;
      if (boot_done !== 1'b0 || cpu_reset !== 1'b1) begin
         errors++;
         $display("FAIL skip_load_ignored: got boot_done=%0b cpu_reset=%0b expected 0 1", boot_done, cpu_reset);
      end
      for (int i = 1; i <= 4; i++) frame();
      checks++;
      if (loading_offset !== 10'd1) begin
         errors++;
         $display("FAIL skip_load_still_loading: got offset=%0d expected 1", loading_offset);
      end
      load_busy = 1'b0;
      tick();
      for (int i = 1; i <= 5; i++) frame();
      skip_req = 1'b1;
      tick();
      skip_req = 1'b0;
      checks++;
      if (boot_done !== 1'b1 || cpu_reset !== 1'b0 || loading_offset !== 10'd0) begin
         errors++;
         $display("FAIL skip_hold5: got boot_done=%0b cpu_reset=%0b offset=%0d expected 1 0 0",
                  boot_done, cpu_reset, loading_offset);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      load_busy = 1'b1;
      tick();
      for (int i = 1; i <= 3; i++) frame();
      frame_start = 1'b1;
      load_busy = 1'b0;
      tick();
      frame_start = 1'b0;
      checks++;
      if (loading_offset !== 10'd0 || cpu_reset !== 1'b1) begin
         errors++;
         $display("FAIL simul_offset: got offset=%0d cpu_reset=%0b expected 0 1", loading_offset, cpu_reset);
      end
      tick();
      finish_hold("simul", 0);
   endtask

   task automatic test_reload();
      // Starts in RUN, left there by test_simultaneous.
      load_busy = 1'b1;
      tick();
      checks++;
      if (cpu_reset !== 1'b1 || logo_enable !== 1'b1 || loading_offset !== 10'd0 || boot_done !== 1'b0) begin
         errors++;
         $display("FAIL reload_entry: got cpu_reset=%0b logo=%0b offset=%0d boot_done=%0b expected 1 1 0 0",
                  cpu_reset, logo_enable, loading_offset, boot_done);
      end
      for (int i = 1; i <= 4; i++) frame();
      checks++;
      if (loading_offset !== 10'd1) begin
         errors++;
         $display("FAIL reload_step: got offset=%0d expected 1", loading_offset);
      end
      load_busy = 1'b0;
      tick();
      finish_hold("reload", 1);
   endtask

   task automatic test_reset_mid_hold();
      int done_seen;
      int cpu_low;
      do_reset();
      load_busy = 1'b1;
      tick();
      for (int i = 1; i <= 8; i++) frame();
      load_busy = 1'b0;
      tick();
      for (int i = 1; i <= 12; i++) frame();
      reset = 1'b1;
      tick();
      checks++;
      if (loading_offset !== 10'd0 || logo_enable !== 1'b1 || cpu_reset !== 1'b1 || boot_done !== 1'b0) begin
         errors++;
         $display("FAIL abort_values: got offset=%0d logo=%0b cpu_reset=%0b boot_done=%0b expected 0 1 1 0",
                  loading_offset, logo_enable, cpu_reset, boot_done);
      end
      reset = 1'b0;
      done_seen = 0;
      cpu_low = 0;
      for (int i = 0; i < 40; i++) begin
         frame();
         if (boot_done !== 1'b0) done_seen++;
         if (cpu_reset !== 1'b1) cpu_low++;
      end
      checks++;
      if (done_seen != 0 || cpu_low != 0) begin
         errors++;
         $display("FAIL abort_no_boot: got done_pulses=%0d cpu_low=%0d expected 0 0", done_seen, cpu_low);
      end
   endtask

   initial begin
      test_reset();
      test_animation();
      test_wrap();
      test_full_boot();
      test_skip();
      test_simultaneous();
      test_reload();
      test_reset_mid_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
